// File: rtl/decap_packet_stream_if.sv
// Valid/ready stream bundle used on both sides of the decapsulator.
// The producer drives data/valid and the consumer drives ready.
interface decap_packet_stream_if #(
    parameter int W = 64
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/decap_packet_stream.sv
// Reassembles one {addr, data} DFX word from a stream of headered Aurora frames.
// Optional macro DECAP_SEQ_CHECK_EN enables sequence-number and final-frame padding checks.
module decap_packet_stream #(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int HDR_WIDTH         = 9,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decap_packet_stream_if.slave  s,
    decap_packet_stream_if.master m,
    output logic                  done_decap_pkt,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);
    localparam int DFX_W      = DATA_WIDTH + ADDR_WIDTH;
    localparam int PL_W       = AURORA_DATA_WIDTH - HDR_WIDTH;
    localparam int NUM_FRAMES = (DFX_W + PL_W - 1) / PL_W;
    localparam int LAST_W     = DFX_W - (NUM_FRAMES - 1) * PL_W;
    localparam int KW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int SEQ_W      = HDR_WIDTH - 2;
    localparam logic [KW-1:0] LAST_K = KW'(NUM_FRAMES - 1);

    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_LONG   = 2'b10;
    localparam logic [1:0] ERR_NO_SOP = 2'b11;

    typedef enum logic [1:0] {IDLE, COLLECT, DROP, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [DFX_W-1:0]       asm_q;
    logic [DFX_W-1:0]       m_data_q;
    logic                   m_valid_q;
    logic                   done_q;
    logic                   err_pulse_q;
    logic [1:0]             err_code_q, err_code_d;
    logic [CNT_WIDTH-1:0]   pkt_cnt_q, err_cnt_q;

    logic                   xfer, sop, eop;
    logic [PL_W-1:0]        payload;
    logic                   wr_en;
    logic [KW-1:0]          wr_idx;
    logic [NUM_FRAMES-1:0]  slice_we;
    logic                   err_ev, load, deliver;
    logic                   seq_bad, pad_bad;

    assign s.ready = rst_n && (state_q != HOLD);
    assign xfer    = s.valid && s.ready;
    assign sop     = s.data[HDR_WIDTH-1];
    assign eop     = s.data[HDR_WIDTH-2];
    assign payload = s.data[AURORA_DATA_WIDTH-1:HDR_WIDTH];

`ifdef DECAP_SEQ_CHECK_EN
    logic [SEQ_W-1:0] seq, seq_exp;
    assign seq     = s.data[SEQ_W-1:0];
    // An SOP frame always opens at index 0, even when it restarts a packet.
    assign seq_exp = (state_q == COLLECT && !sop) ? SEQ_W'(k_q) : '0;
    assign seq_bad = (seq != seq_exp);
    if (LAST_W < PL_W) begin : g_pad
        assign pad_bad = (k_q == LAST_K) && (|payload[PL_W-1:LAST_W]);
    end else begin : g_nopad
        assign pad_bad = 1'b0;
    end
`else
    assign seq_bad = 1'b0;
    assign pad_bad = 1'b0;
`endif

    genvar gi;
    for (gi = 0; gi < NUM_FRAMES; gi++) begin : g_we
        assign slice_we[gi] = wr_en && (wr_idx == KW'(gi));
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        wr_en      = 1'b0;
        wr_idx     = k_q;
        err_ev     = 1'b0;
        err_code_d = err_code_q;
        load       = 1'b0;
        deliver    = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (!sop) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_NO_SOP;
                    end else if (eop) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_SHORT;
                    end else if (seq_bad) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_LONG;
                        state_d    = DROP;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        k_d     = KW'(1);
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (xfer) begin
                    if (sop) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_SHORT;
                        if (eop) begin
                            state_d = IDLE;
                        end else if (seq_bad) begin
                            state_d = DROP;
                        end else begin
                            wr_en  = 1'b1;
                            wr_idx = '0;
                            k_d    = KW'(1);
                        end
                    end else if (seq_bad || pad_bad) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_LONG;
                        state_d    = eop ? IDLE : DROP;
                    end else if (k_q == LAST_K) begin
                        if (eop) begin
                            wr_en   = 1'b1;
                            state_d = HOLD;
                        end else begin
                            err_ev     = 1'b1;
                            err_code_d = ERR_LONG;
                            state_d    = DROP;
                        end
                    end else if (eop) begin
                        err_ev     = 1'b1;
                        err_code_d = ERR_SHORT;
                        state_d    = IDLE;
                    end else begin
                        wr_en = 1'b1;
                        k_d   = k_q + KW'(1);
                    end
                end
            end
            DROP: begin
                if (xfer && eop) state_d = IDLE;
            end
            HOLD: begin
                // First HOLD cycle copies the assembly register into the output buffer.
                if (!m_valid_q) begin
                    load = 1'b1;
                end else if (m.ready) begin
                    deliver = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            asm_q       <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            done_q      <= load;
            err_pulse_q <= err_ev;
            if (err_ev) begin
                err_code_q <= err_code_d;
                if (~&err_cnt_q) err_cnt_q <= err_cnt_q + 1'b1;
            end
            if (load) begin
                m_data_q  <= asm_q;
                m_valid_q <= 1'b1;
            end else if (deliver) begin
                m_valid_q <= 1'b0;
            end
            if (deliver && ~&pkt_cnt_q) pkt_cnt_q <= pkt_cnt_q + 1'b1;
            for (int i = 0; i < NUM_FRAMES - 1; i++) begin
                if (slice_we[i]) asm_q[i*PL_W +: PL_W] <= payload;
            end
            // The final frame only contributes its low LAST_W payload bits.
            if (slice_we[NUM_FRAMES-1]) asm_q[DFX_W-1 -: LAST_W] <= payload[LAST_W-1:0];
        end
    end

    assign m.data         = m_data_q;
    assign m.valid        = m_valid_q;
    assign done_decap_pkt = done_q;
    assign err_pulse      = err_pulse_q;
    assign err_code       = err_code_q;
    assign pkt_cnt        = pkt_cnt_q;
    assign err_cnt        = err_cnt_q;
endmodule

// File: tb/tb_decap_packet_stream.sv
// Randomized bench for decap_packet_stream, checked every cycle against a
// packet-level reference model that accumulates payloads arithmetically.
module tb_decap_packet_stream;
    localparam int AW     = 64;
    localparam int CW     = 16;
    localparam int DFX_W  = 1034;
    localparam int PL_W   = 55;
    localparam int NF     = 19;
    localparam int LAST_W = 44;
`ifdef DECAP_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    typedef enum int {M_IDLE, M_COLL, M_DROP, M_HOLD} mode_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          done, errp;
    logic [1:0]    code;
    logic [CW-1:0] pkt, errc;

    decap_packet_stream_if #(.W(AW))    s_if ();
    decap_packet_stream_if #(.W(DFX_W)) m_if ();

    decap_packet_stream dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s              (s_if),
        .m              (m_if),
        .done_decap_pkt (done),
        .err_pulse      (errp),
        .err_code       (code),
        .pkt_cnt        (pkt),
        .err_cnt        (errc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    mode_t            mode = M_IDLE;
    logic [DFX_W-1:0] acc = '0;
    logic [DFX_W-1:0] e_mdata = '0;
    int               nfr = 0;
    bit               e_mvalid = 0, e_done = 0, e_errp = 0;
    logic [1:0]       e_code = 2'b00;
    int               e_pkt = 0, e_err = 0;
    logic [63:0]      pq[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DFX_W-1:0] place(input logic [DFX_W-1:0] w, input int k,
                                               input logic [PL_W-1:0] pl);
        logic [DFX_W-1:0] ext;
        ext = DFX_W'(pl);
        return w | (ext << (k * PL_W));
    endfunction

    task automatic model_err(input int c);
        e_errp = 1'b1;
        e_code = 2'(c);
        if (e_err < 65535) e_err++;
        $display("[TB] framing error code=%0d err_cnt=%0d", c, e_err);
    endtask

    task automatic model_edge(input bit rn, input bit xfer, input logic [63:0] f, input bit mr);
        bit sop, eop, bad;
        logic [6:0] seq;
        logic [PL_W-1:0] pl;
        sop = f[8];
        eop = f[7];
        seq = f[6:0];
        pl  = f[63:9];
        e_done = 1'b0;
        e_errp = 1'b0;
        if (!rn) begin
            mode = M_IDLE; acc = '0; e_mdata = '0; nfr = 0;
            e_mvalid = 1'b0; e_code = 2'b00; e_pkt = 0; e_err = 0;
        end else if (mode == M_HOLD) begin
            if (!e_mvalid) begin
                e_mvalid = 1'b1;
                e_done   = 1'b1;
                e_mdata  = acc;
                $display("[TB] word ready addr=%0d", acc[DFX_W-1:DFX_W-10]);
            end else if (mr) begin
                e_mvalid = 1'b0;
                if (e_pkt < 65535) e_pkt++;
                mode = M_IDLE;
                $display("[TB] word delivered pkt_cnt=%0d", e_pkt);
            end
        end else if (xfer) begin
            case (mode)
                M_IDLE: begin
                    if (!sop) model_err(3);
                    else if (eop) model_err(1);
                    else if (SEQ_ON && seq != 7'd0) begin model_err(2); mode = M_DROP; end
                    else begin acc = place('0, 0, pl); nfr = 1; mode = M_COLL; end
                end
                M_COLL: begin
                    if (sop) begin
                        model_err(1);
                        if (eop) mode = M_IDLE;
                        else if (SEQ_ON && seq != 7'd0) mode = M_DROP;
                        else begin acc = place('0, 0, pl); nfr = 1; end
                    end else begin
                        bad = SEQ_ON && ((seq != 7'(nfr % 128)) ||
                                         (nfr == NF - 1 && (pl >> LAST_W) != '0));
                        if (bad) begin
                            model_err(2);
                            mode = eop ? M_IDLE : M_DROP;
                        end else begin
                            acc = place(acc, nfr, pl);
                            if (nfr == NF - 1) begin
                                if (eop) mode = M_HOLD;
                                else begin model_err(2); mode = M_DROP; end
                            end else if (eop) begin
                                model_err(1);
                                mode = M_IDLE;
                            end
                            nfr++;
                        end
                    end
                end
                M_DROP: if (eop) mode = M_IDLE;
                default: mode = M_IDLE;
            endcase
        end
    endtask

    task automatic cycle(input bit v, input logic [63:0] f, input bit mr, input bit rn, output bit xfer);
        bit er;
        int idx;
        logic [DFX_W-1:0] got_sh, exp_sh;
        s_if.valid = v;
        s_if.data  = f;
        m_if.ready = mr;
        rst_n      = rn;
        #1;
        er = rn && (mode != M_HOLD);
        check_val("s_ready", 64'(s_if.ready), 64'(er));
        xfer = v && er;
        @(posedge clk);
        model_edge(rn, xfer, f, mr);
        #1;
        check_val("m_valid", 64'(m_if.valid), 64'(e_mvalid));
        check_val("done", 64'(done), 64'(e_done));
        check_val("err_pulse", 64'(errp), 64'(e_errp));
        check_val("err_code", 64'(code), 64'(e_code));
        check_val("pkt_cnt", 64'(pkt), 64'(e_pkt));
        check_val("err_cnt", 64'(errc), 64'(e_err));
        idx = 0;
        for (int k = 0; k < NF; k++) begin
            got_sh = m_if.data >> (k * PL_W);
            exp_sh = e_mdata >> (k * PL_W);
            if (got_sh[PL_W-1:0] !== exp_sh[PL_W-1:0]) begin idx = k; break; end
        end
        got_sh = m_if.data >> (idx * PL_W);
        exp_sh = e_mdata >> (idx * PL_W);
        check_val("m_data_chunk", 64'(got_sh[PL_W-1:0]), 64'(exp_sh[PL_W-1:0]));
    endtask

    function automatic bit pick_mr(input int pol);
        if (pol == 0) return 1'b1;
        if (pol == 2) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic idle(input int n, input int pol);
        bit x;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, pick_mr(pol), 1'b1, x);
    endtask

    task automatic send_frame(input logic [63:0] f, input int pol);
        bit x;
        int tries;
        tries = 0;
        x = 1'b0;
        while (!x && tries < 200) begin
            cycle(1'b1, f, pick_mr(pol), 1'b1, x);
            tries++;
        end
        if (!x) check_val("accept_timeout", 64'(tries), 64'(0));
    endtask

    task automatic send(input int pol);
        foreach (pq[i]) send_frame(pq[i], pol);
    endtask

    function automatic logic [63:0] mkf(input logic [PL_W-1:0] pl, input bit sop, input bit eop,
                                        input logic [6:0] seq);
        return {pl, sop, eop, seq};
    endfunction

    task automatic build(input int n, input int eop_at, input bit rnd, input logic [PL_W-1:0] base);
        logic [PL_W-1:0] pl;
        pq.delete();
        for (int k = 0; k < n; k++) begin
            pl = rnd ? PL_W'({$urandom(), $urandom()}) : base + PL_W'(k);
            if (k == NF - 1) pl[PL_W-1:LAST_W] = '0;
            pq.push_back(mkf(pl, k == 0, k == eop_at, 7'(k)));
        end
    endtask

    initial begin
        logic [63:0] base64;
        logic [PL_W-1:0] base;
        bit x;
        int kind, n;
        base64 = 64'h0AA_0000_0000_0000;
        base   = base64[PL_W-1:0];

        cycle(1'b0, '0, 1'b1, 1'b0, x);
        cycle(1'b0, '0, 1'b1, 1'b0, x);
        idle(2, 0);

        // Good packet with constant-plus-index payloads
        build(NF, NF - 1, 1'b0, base);
        send(0);
        idle(3, 0);

        // Backpressure: hold the word for 10 cycles, then release while the next packet waits
        build(NF, NF - 1, 1'b1, '0);
        send(2);
        idle(10, 2);
        build(NF, NF - 1, 1'b1, '0);
        send(0);
        idle(3, 0);

        // Short packet followed by a good one
        build(6, 5, 1'b1, '0);
        send(0);
        build(NF, NF - 1, 1'b1, '0);
        send(0);
        idle(3, 0);

        // Long packet
        build(22, 21, 1'b1, '0);
        send(0);
        idle(2, 0);

        // Missing SOP
        pq.delete();
        pq.push_back(mkf(PL_W'(123), 1'b0, 1'b0, 7'd0));
        send(0);
        idle(2, 0);

        // Reset during frame 10, then a fresh packet
        build(NF, NF - 1, 1'b1, '0);
        for (int i = 0; i < 10; i++) send_frame(pq[i], 0);
        cycle(1'b1, pq[10], 1'b1, 1'b0, x);
        idle(1, 0);
        build(NF, NF - 1, 1'b1, '0);
        send(0);
        idle(3, 0);

        // Frame 7 carries the wrong sequence number
        build(NF, NF - 1, 1'b1, '0);
        pq[7][6:0] = 7'd8;
        send(0);
        idle(3, 0);

        // Nonzero bits above the final frame's used payload
        build(NF, NF - 1, 1'b1, '0);
        pq[NF-1][63] = 1'b1;
        send(0);
        idle(3, 0);

        // Abandoned packet restarted by a new SOP
        build(7, -1, 1'b1, '0);
        send(0);
        build(NF, NF - 1, 1'b1, '0);
        send(0);
        idle(3, 0);

        // Random mix with random backpressure and gaps
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: build(NF, NF - 1, 1'b1, '0);
                2: begin n = $urandom_range(1, NF - 1); build(n, n - 1, 1'b1, '0); end
                3: begin n = $urandom_range(NF + 1, NF + 5); build(n, n - 1, 1'b1, '0); end
                4: begin
                    pq.delete();
                    pq.push_back(mkf(PL_W'($urandom()), 1'b0, 1'($urandom_range(0, 1)), 7'd0));
                end
                default: begin n = $urandom_range(1, NF - 1); build(n, -1, 1'b1, '0); end
            endcase
            send(1);
            idle($urandom_range(0, 3), 1);
        end
        idle(6, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
